apb3_master_fsm: RTL and testbench
==================================

Name: apb3_master_fsm

Overview:
- Parametrised next-generation APB bridge controller: converts AHB transfers into APB3 transfers.
- Adds features over the earlier controller: PREADY wait states, PSLVERR mapped to a two-cycle AHB ERROR response, an access timeout, and an optional one-deep posted-write buffer.
- Sits between the AHB slave interface (address/data pipeline registers, slave decoder) and the APB peripheral bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NSLV, 3, number of APB slaves (width of Pselx/tempselx)
POSTED_WR, 0, 1 = complete AHB writes at data phase, before APB completion
TIMEOUT_CYC, 16, max ACCESS cycles without Pready (0 = timeout disabled)

Ports:
Hclk  in  1  clock
Hreset  in  1  asynchronous active-high reset
valid  in  1  qualified AHB NONSEQ/SEQ address phase
Hwrite  in  1  AHB direction, valid with valid
Haddr  in  ADDR_W  AHB address, valid with valid
Hwdata  in  DATA_W  AHB write data, data phase
tempselx  in  NSLV  one-hot slave decode of Haddr; all-zero = unmapped
Prdata  in  DATA_W  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error, sampled with Pready
err_clr  in  1  clears Perr_sticky
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB direction
Pselx  out  NSLV  APB one-hot select
Penable  out  1  APB enable
Hreadyout  out  1  AHB ready
Hresp  out  1  AHB response, 1 = ERROR
Hrdata  out  DATA_W  read data returned to AHB
Perr_sticky  out  1  posted-write error/timeout flag

Behaviour:
- Reset: asynchronous, active-high. Clock is Hclk; reset is Hreset.
- Reset values: all outputs 0 except Hreadyout = 1. State = IDLE; pending slot empty; timeout counter cleared.
- Reset asserted mid-transfer drops Pselx/Penable immediately; the interrupted transfer is lost.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- Hreadyout is Moore-decoded:
  - IDLE = 1, ERR2 = 1
  - WWAIT = POSTED_WR
  - SETUP, ACCESS, ERR1 = 0
- Hresp = 1 only in ERR1 and ERR2.
- Transfer acceptance:
  - A transfer is accepted when valid = 1 in IDLE or ERR2.
  - On acceptance, latch Haddr, Hwrite and tempselx.
  - tempselx == 0 (unmapped): go to ERR1; no APB access; applies for both reads and writes.
  - Mapped read: go to SETUP.
  - Mapped write: go to WWAIT.
- WWAIT: capture Hwdata into Pwdata; go to SETUP.
- POSTED_WR = 1 and valid in WWAIT:
  - Latch that transfer into the pending slot.
  - Hreadyout stays low through SETUP/ACCESS, so the AHB master holds Hwdata stable.
- SETUP (one cycle): Pselx = latched select, Paddr/Pwrite driven, Penable = 0; go to ACCESS.
- ACCESS: Penable = 1; stays in ACCESS while Pready = 0.
- On Pready = 1 in ACCESS:
  - Read: Hrdata <= Prdata.
  - Drop Pselx and Penable.
  - Non-posted transfer with Pslverr = 1: go to ERR1.
  - Posted write with Pslverr = 1: set Perr_sticky; no Hresp.
  - Otherwise, if the pending slot is full: load it; a pending write captures Hwdata this cycle; go to SETUP (Pselx held 0 for one cycle).
  - Otherwise: go to IDLE.
- Timeout (TIMEOUT_CYC > 0):
  - Counter increments each ACCESS cycle and clears on SETUP.
  - When it reaches TIMEOUT_CYC with Pready = 0, treat as Pready = 1 with Pslverr = 1.
- ERR1 -> ERR2 unconditionally; ERR2 decodes valid exactly as IDLE.
- Perr_sticky:
  - Set has priority over err_clr in the same cycle.
  - Held until err_clr is asserted.
- APB signals are stable from SETUP until the ACCESS exit.

Test Plan:
- Read, Pready tied 1: valid, Haddr = 0x0000_0040, tempselx = 3'b010, Prdata = 0xDEAD_BEEF -> SETUP at T+1 (Pselx = 010, Penable = 0), ACCESS at T+2, Hreadyout = 1 and Hrdata = 0xDEAD_BEEF at T+3.
- Write with 3 wait states, POSTED_WR = 0: Hwdata = 0x1234_5678 -> Pwdata = 0x1234_5678, Penable high 4 cycles, Hreadyout low from T+1 to T+6, high at T+7.
- Pslverr on read -> ERR1 (Hreadyout = 0, Hresp = 1), then ERR2 (Hreadyout = 1, Hresp = 1), then IDLE with Hresp = 0.
- POSTED_WR = 1: write A, then read B issued in the WWAIT cycle; A gets Pslverr -> Hreadyout = 1 at WWAIT, Perr_sticky = 1, B proceeds normally with no Hresp; err_clr -> Perr_sticky = 0.
- TIMEOUT_CYC = 16 with Pready stuck 0 -> Penable drops after exactly 16 ACCESS cycles, ERR1/ERR2 response follows; tempselx = 0 -> ERR1 at T+1 with Pselx never asserted.
- Assert Hreset during ACCESS -> Pselx = 0, Penable = 0, Hreadyout = 1 without a clock edge; after release, a new read completes normally.

Source files
------------

// File: rtl/apb3_master_fsm.sv
// AHB-to-APB3 bridge controller: wait states, slave-error to AHB ERROR response,
// access timeout and an optional one-deep posted-write slot.
module apb3_master_fsm #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NSLV        = 3,
    parameter int unsigned POSTED_WR   = 0,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Perr_sticky
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t            state;
    logic [NSLV-1:0]   sel_q;
    logic              gap;
    logic              pend_vld;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [NSLV-1:0]   pend_sel;
    logic [CNT_W-1:0]  cnt;

    logic tmo;
    logic done;
    logic err;
    logic posted;

    // A timeout behaves exactly like a completing transfer that reported an error.
    assign tmo    = (TIMEOUT_CYC != 0) && !Pready && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign done   = Pready | tmo;
    assign err    = (Pready & Pslverr) | tmo;
    assign posted = (POSTED_WR != 0) && Pwrite;

    // {Hreadyout, Hresp} for the state being entered.
    function automatic logic [1:0] rsp(input state_t s);
        case (s)
            IDLE:    rsp = 2'b10;
            ERR2:    rsp = 2'b11;
            ERR1:    rsp = 2'b01;
            WWAIT:   rsp = {(POSTED_WR != 0), 1'b0};
            default: rsp = 2'b00;
        endcase
    endfunction

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state       <= IDLE;
            sel_q       <= '0;
            gap         <= 1'b0;
            pend_vld    <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_sel    <= '0;
            cnt         <= '0;
            Paddr       <= '0;
            Pwdata      <= '0;
            Pwrite      <= 1'b0;
            Pselx       <= '0;
            Penable     <= 1'b0;
            Hreadyout   <= 1'b1;
            Hresp       <= 1'b0;
            Hrdata      <= '0;
            Perr_sticky <= 1'b0;
        end else begin
            // A set later in this block overrides this clear.
            if (err_clr) Perr_sticky <= 1'b0;

            case (state)
                IDLE, ERR2: begin
                    if (valid) begin
                        Paddr  <= Haddr;
                        Pwrite <= Hwrite;
                        sel_q  <= tempselx;
                        if (tempselx == '0) begin
                            state               <= ERR1;
                            {Hreadyout, Hresp}  <= rsp(ERR1);
                        end else if (Hwrite) begin
                            state               <= WWAIT;
                            {Hreadyout, Hresp}  <= rsp(WWAIT);
                        end else begin
                            Pselx               <= tempselx;
                            state               <= SETUP;
                            {Hreadyout, Hresp}  <= rsp(SETUP);
                        end
                    end else begin
                        state              <= IDLE;
                        {Hreadyout, Hresp} <= rsp(IDLE);
                    end
                end

                WWAIT: begin
                    Pwdata             <= Hwdata;
                    Pselx              <= sel_q;
                    state              <= SETUP;
                    {Hreadyout, Hresp} <= rsp(SETUP);
                    if ((POSTED_WR != 0) && valid) begin
                        pend_vld  <= 1'b1;
                        pend_wr   <= Hwrite;
                        pend_addr <= Haddr;
                        pend_sel  <= tempselx;
                    end
                end

                SETUP: begin
                    cnt <= '0;
                    // After a pending reload the select stays low one cycle before the real SETUP.
                    if (gap) begin
                        gap   <= 1'b0;
                        Pselx <= sel_q;
                    end else begin
                        Penable            <= 1'b1;
                        state              <= ACCESS;
                        {Hreadyout, Hresp} <= rsp(ACCESS);
                    end
                end

                ACCESS: begin
                    if (!done) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        Pselx   <= '0;
                        Penable <= 1'b0;
                        if (!Pwrite) Hrdata <= Prdata;
                        if (err && !posted) begin
                            state              <= ERR1;
                            {Hreadyout, Hresp} <= rsp(ERR1);
                        end else begin
                            if (err) Perr_sticky <= 1'b1;
                            if (pend_vld) begin
                                pend_vld <= 1'b0;
                                Paddr    <= pend_addr;
                                Pwrite   <= pend_wr;
                                sel_q    <= pend_sel;
                                if (pend_wr) Pwdata <= Hwdata;
                                if (pend_sel == '0) begin
                                    state              <= ERR1;
                                    {Hreadyout, Hresp} <= rsp(ERR1);
                                end else begin
                                    gap                <= 1'b1;
                                    state              <= SETUP;
                                    {Hreadyout, Hresp} <= rsp(SETUP);
                                end
                            end else begin
                                state              <= IDLE;
                                {Hreadyout, Hresp} <= rsp(IDLE);
                            end
                        end
                    end
                end

                ERR1: begin
                    state              <= ERR2;
                    {Hreadyout, Hresp} <= rsp(ERR2);
                end

                default: begin
                    state              <= IDLE;
                    {Hreadyout, Hresp} <= rsp(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_master_fsm.sv
// Directed bench for apb3_master_fsm: one non-posted instance (a_*) and one
// posted-write instance (b_*) share the same stimulus.
module tb_apb3_master_fsm;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        valid, Hwrite, Pready, Pslverr, err_clr;
    logic [31:0] Haddr, Hwdata, Prdata;
    logic [2:0]  tempselx;

    logic [31:0] a_paddr, a_pwdata, a_hrdata, b_paddr, b_pwdata, b_hrdata;
    logic        a_pwrite, a_penable, a_hready, a_hresp, a_sticky;
    logic        b_pwrite, b_penable, b_hready, b_hresp, b_sticky;
    logic [2:0]  a_psel, b_psel;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 Hclk = ~Hclk;

    apb3_master_fsm #(.POSTED_WR(0), .TIMEOUT_CYC(16)) dut_a (
        .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite), .Haddr(Haddr),
        .Hwdata(Hwdata), .tempselx(tempselx), .Prdata(Prdata), .Pready(Pready),
        .Pslverr(Pslverr), .err_clr(err_clr), .Paddr(a_paddr), .Pwdata(a_pwdata),
        .Pwrite(a_pwrite), .Pselx(a_psel), .Penable(a_penable), .Hreadyout(a_hready),
        .Hresp(a_hresp), .Hrdata(a_hrdata), .Perr_sticky(a_sticky)
    );

    apb3_master_fsm #(.POSTED_WR(1), .TIMEOUT_CYC(16)) dut_b (
        .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite), .Haddr(Haddr),
        .Hwdata(Hwdata), .tempselx(tempselx), .Prdata(Prdata), .Pready(Pready),
        .Pslverr(Pslverr), .err_clr(err_clr), .Paddr(b_paddr), .Pwdata(b_pwdata),
        .Pwrite(b_pwrite), .Pselx(b_psel), .Penable(b_penable), .Hreadyout(b_hready),
        .Hresp(b_hresp), .Hrdata(b_hrdata), .Perr_sticky(b_sticky)
    );

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s);
        valid    = v;
        Hwrite   = w;
        Haddr    = a;
        tempselx = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Hreset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        Hwdata = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0; err_clr = 1'b0;
        step();
        chk("rst_hready", a_hready, 1);
        chk("rst_hresp", a_hresp, 0);
        chk("rst_psel", a_psel, 0);
        chk("rst_penable", a_penable, 0);
        chk("rst_paddr", a_paddr, 0);
        chk("rst_hrdata", a_hrdata, 0);
        chk("rst_sticky", a_sticky, 0);
        Hreset = 1'b0;
        step();

        // Read with Pready tied high
        drive(1'b1, 1'b0, 32'h0000_0040, 3'b010);
        Pready = 1'b1; Prdata = 32'hDEAD_BEEF;
        step();
        chk("rd_setup_psel", a_psel, 3'b010);
        chk("rd_setup_penable", a_penable, 0);
        chk("rd_setup_paddr", a_paddr, 32'h40);
        chk("rd_setup_hready", a_hready, 0);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        chk("rd_access_penable", a_penable, 1);
        chk("rd_access_psel", a_psel, 3'b010);
        step();
        chk("rd_done_hready", a_hready, 1);
        chk("rd_done_hrdata", a_hrdata, 32'hDEAD_BEEF);
        chk("rd_done_psel", a_psel, 0);
        chk("rd_done_penable", a_penable, 0);

        // Non-posted write, three wait states
        Pready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0080, 3'b001);
        step();
        chk("wr_wwait_hready", a_hready, 0);
        chk("wr_wwait_psel", a_psel, 0);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        Hwdata = 32'h1234_5678;
        step();
        chk("wr_setup_pwdata", a_pwdata, 32'h1234_5678);
        chk("wr_setup_psel", a_psel, 3'b001);
        chk("wr_setup_penable", a_penable, 0);
        chk("wr_setup_pwrite", a_pwrite, 1);
        step();
        n = 0;
        while (a_penable && n < 20) begin
            if (n == 3) Pready = 1'b1;
            chk("wr_access_hready", a_hready, 0);
            n++;
            step();
        end
        chk("wr_penable_cycles", n, 4);
        chk("wr_done_hready", a_hready, 1);
        chk("wr_done_hresp", a_hresp, 0);

        // Slave error on a read
        Pready = 1'b1; Pslverr = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0044, 3'b100);
        step();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        chk("serr_access_penable", a_penable, 1);
        step();
        chk("serr_err1_hready", a_hready, 0);
        chk("serr_err1_hresp", a_hresp, 1);
        chk("serr_err1_psel", a_psel, 0);
        Pslverr = 1'b0;
        step();
        chk("serr_err2_hready", a_hready, 1);
        chk("serr_err2_hresp", a_hresp, 1);
        step();
        chk("serr_idle_hresp", a_hresp, 0);
        chk("serr_idle_hready", a_hready, 1);

        // Timeout with Pready stuck low
        Pready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0048, 3'b010);
        step();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        n = 0;
        while (a_penable && n < 40) begin
            n++;
            step();
        end
        chk("tmo_access_cycles", n, 16);
        chk("tmo_err1_hresp", a_hresp, 1);
        chk("tmo_err1_hready", a_hready, 0);
        step();
        chk("tmo_err2_hready", a_hready, 1);
        chk("tmo_err2_hresp", a_hresp, 1);
        step();
        chk("tmo_idle_hresp", a_hresp, 0);
        chk("tmo_sticky", a_sticky, 0);

        // Unmapped write, then a read accepted straight out of ERR2
        drive(1'b1, 1'b1, 32'h0000_0F00, 3'b000);
        step();
        chk("unm_err1_hresp", a_hresp, 1);
        chk("unm_err1_hready", a_hready, 0);
        chk("unm_err1_psel", a_psel, 0);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        chk("unm_err2_hready", a_hready, 1);
        chk("unm_err2_psel", a_psel, 0);
        drive(1'b1, 1'b0, 32'h0000_0050, 3'b001);
        Pready = 1'b1; Prdata = 32'hCAFE_F00D;
        step();
        chk("err2_acc_psel", a_psel, 3'b001);
        chk("err2_acc_hresp", a_hresp, 0);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        step();
        chk("err2_acc_hrdata", a_hrdata, 32'hCAFE_F00D);
        chk("err2_acc_hready", a_hready, 1);

        // Reset asserted during ACCESS
        Pready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0060, 3'b100);
        step();
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        chk("rst_mid_penable_before", a_penable, 1);
        #2 Hreset = 1'b1;
        #1;
        chk("rst_mid_psel", a_psel, 0);
        chk("rst_mid_penable", a_penable, 0);
        chk("rst_mid_hready", a_hready, 1);
        step();
        Hreset = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0064, 3'b001);
        Pready = 1'b1; Prdata = 32'h55AA_55AA;
        step();
        chk("post_rst_psel", a_psel, 3'b001);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        step();
        step();
        chk("post_rst_hrdata", a_hrdata, 32'h55AA_55AA);
        chk("post_rst_hready", a_hready, 1);

        // Posted write A errors; read B issued during WWAIT proceeds cleanly
        Pready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0070, 3'b001);
        step();
        chk("pw_wwait_hready", b_hready, 1);
        drive(1'b1, 1'b0, 32'h0000_0074, 3'b010);
        Hwdata = 32'hA1A1_A1A1;
        step();
        chk("pw_setup_pwdata", b_pwdata, 32'hA1A1_A1A1);
        chk("pw_setup_paddr", b_paddr, 32'h70);
        chk("pw_setup_psel", b_psel, 3'b001);
        chk("pw_setup_hready", b_hready, 0);
        drive(1'b0, 1'b0, 32'h0, 3'b000);
        Pready = 1'b1; Pslverr = 1'b1;
        step();
        chk("pw_access_penable", b_penable, 1);
        step();
        chk("pw_gap_sticky", b_sticky, 1);
        chk("pw_gap_psel", b_psel, 0);
        chk("pw_gap_hresp", b_hresp, 0);
        chk("pw_gap_hready", b_hready, 0);
        chk("pw_gap_paddr", b_paddr, 32'h74);
        chk("np_wr_err1_hresp", a_hresp, 1);
        Pslverr = 1'b0; Prdata = 32'hBBBB_0001;
        step();
        chk("pw_b_setup_psel", b_psel, 3'b010);
        chk("pw_b_setup_pwrite", b_pwrite, 0);
        chk("pw_b_setup_penable", b_penable, 0);
        step();
        chk("pw_b_access_penable", b_penable, 1);
        step();
        chk("pw_b_done_hready", b_hready, 1);
        chk("pw_b_done_hresp", b_hresp, 0);
        chk("pw_b_done_hrdata", b_hrdata, 32'hBBBB_0001);
        chk("pw_sticky_held", b_sticky, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("pw_sticky_cleared", b_sticky, 0);
        chk("np_sticky_never", a_sticky, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
